// File: rtl/seg7_pkg.sv
// seg7_pkg: shared state type, blank pattern and hex glyph table for the 7-segment scan controller
//   Exports: state_t (ST_IDLE/ST_BLANK/ST_DRIVE), SEG_BLANK, GLYPHS, hex_to_seg(nibble)
package seg7_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction
endpackage

// File: rtl/seg7_hex_lut.sv
// seg7_hex_lut: combinational hex nibble to active-low segment pattern (a..g on bits 0..6)
//   nibble in  4  hex digit
//   seg    out 7  active-low segments
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb seg = hex_to_seg(nibble);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-segment scan controller with double-buffered digits
//   clk, rst_n (sync, active-low), enable (scan run), wr_en/wr_addr/wr_data (shadow store write)
//   seg_n (active-low segments), dig_n (active-low digit selects), frame_done (pulse on frame wrap)
//   Option macro SEG7_LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown)
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  output logic [6:0]                    seg_n,
  output logic [NUM_DIGITS-1:0]         dig_n,
  output logic                          frame_done
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2((DIGIT_TICKS > BLANK_TICKS ? DIGIT_TICKS : BLANK_TICKS) + 1);
  localparam logic [CW-1:0] BT_LAST = CW'(BLANK_TICKS > 0 ? BLANK_TICKS - 1 : 0);
  localparam logic [CW-1:0] DT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);
  localparam state_t ST_NEXT = BLANK_TICKS == 0 ? ST_DRIVE : ST_BLANK;
  state_t state, nxt_state;
  logic [AW-1:0] idx, nxt_idx;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [3:0] shadow [NUM_DIGITS];
  logic [3:0] active [NUM_DIGITS];
  logic [3:0] nxt_active [NUM_DIGITS];
  logic wrap, copy, lz;
  logic [3:0] lut_in;
  logic [6:0] lut_seg;
  always_comb begin
    nxt_state = state;
    nxt_idx = idx;
    nxt_cnt = cnt + 1'b1;
    wrap = 1'b0;
    if (!enable) begin
      nxt_state = ST_IDLE;
      nxt_idx = '0;
      nxt_cnt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          nxt_state = ST_NEXT;
          nxt_idx = '0;
          nxt_cnt = '0;
        end
        ST_BLANK: if (cnt == BT_LAST) begin
          nxt_state = ST_DRIVE;
          nxt_cnt = '0;
        end
        ST_DRIVE: if (cnt == DT_LAST) begin
          nxt_state = ST_NEXT;
          nxt_cnt = '0;
          wrap = idx == LAST_IDX;
          nxt_idx = wrap ? '0 : idx + 1'b1;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
    // The display path looks at the store as it will be after this edge, so a
    // wrap copy is visible in the very first driven cycle of the new frame.
    copy = wrap || state == ST_IDLE;
    for (int i = 0; i < NUM_DIGITS; i++) nxt_active[i] = copy ? shadow[i] : active[i];
    lut_in = nxt_active[nxt_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz = nxt_idx != '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (i >= int'(nxt_idx) && nxt_active[i] != 4'h0) lz = 1'b0;
`else
    lz = 1'b0;
`endif
  end
  seg7_hex_lut u_lut (.nibble(lut_in), .seg(lut_seg));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      cnt <= '0;
      seg_n <= SEG_BLANK;
      dig_n <= '1;
      frame_done <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state <= nxt_state;
      idx <= nxt_idx;
      cnt <= nxt_cnt;
      frame_done <= wrap;
      seg_n <= (nxt_state == ST_DRIVE && !lz) ? lut_seg : SEG_BLANK;
      dig_n <= nxt_state == ST_DRIVE ? ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << nxt_idx) : '1;
      for (int i = 0; i < NUM_DIGITS; i++) active[i] <= nxt_active[i];
      if (wr_en && int'(wr_addr) < NUM_DIGITS) shadow[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed self-checking bench for seg7_scan_ctrl (gapped and gapless builds)
module tb_seg7_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [6:0] seg_n, seg0_n;
  logic [3:0] dig_n, dig0_n;
  logic frame_done, fd0;
  int tests = 0, fails = 0;
  int z_ticks = 0, z_dark = 0, z_last = -1, z_period = 0, z_pulses = 0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z_HI = 7'h7F;
`else
  localparam logic [6:0] Z_HI = 7'h40;
`endif
  always #5 clk = ~clk;
  seg7_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_TICKS(4), .BLANK_TICKS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seg_n(seg_n), .dig_n(dig_n), .frame_done(frame_done)
  );
  seg7_scan_ctrl #(.NUM_DIGITS(4), .DIGIT_TICKS(4), .BLANK_TICKS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .seg_n(seg0_n), .dig_n(dig0_n), .frame_done(fd0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    z_ticks++;
    if (dig0_n == 4'hF) z_dark++;
    if (fd0) begin
      z_pulses++;
      if (z_last >= 0) z_period = z_ticks - z_last;
      z_last = z_ticks;
    end
  endtask
  // One full frame of the gapped DUT starting at its first blank cycle; segs = {d3,d2,d1,d0}.
  // Optionally raises a one-cycle write after drive tick wt of digit wd.
  task automatic run_frame(input string name, input logic [27:0] segs, input bit first,
                           input int wd, input int wt, input logic [1:0] wa, input logic [3:0] wv);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 6; k++) begin
        tick();
        wr_en = 1'b0;
        if (k < 2)
          check($sformatf("%s_d%0d_blank%0d", name, d, k), {frame_done, dig_n, seg_n},
                {(d == 0 && k == 0 && !first), 4'hF, 7'h7F});
        else
          check($sformatf("%s_d%0d_drive%0d", name, d, k - 2), {frame_done, dig_n, seg_n},
                {1'b0, ~(4'b0001 << d), segs[d*7 +: 7]});
        if (d == wd && k == wt + 2) begin
          wr_en = 1'b1;
          wr_addr = wa;
          wr_data = wv;
        end
      end
  endtask
  initial begin
    enable = 1'b1;
    wr_en = 1'b1;
    wr_data = 4'h9;
    repeat (3) tick();
    check("rst_out", {frame_done, dig_n, seg_n}, {1'b0, 4'hF, 7'h7F});
    check("rst_out_nogap", {fd0, dig0_n, seg0_n}, {1'b0, 4'hF, 7'h7F});
    rst_n = 1'b1;
    wr_en = 1'b0;
    run_frame("rst_store", {4{7'h40}}, 1'b1, -1, 0, 2'd0, 4'h0);
    enable = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_addr = 2'(i);
      wr_data = 4'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    enable = 1'b1;
    z_ticks = 0; z_dark = 0; z_last = -1; z_period = 0; z_pulses = 0;
    run_frame("fA", {7'h19, 7'h30, 7'h24, 7'h79}, 1'b1, 1, 0, 2'd0, 4'hF);
    run_frame("fB", {7'h19, 7'h30, 7'h24, 7'h0E}, 1'b0, 3, 3, 2'd1, 4'hA);
    run_frame("fC", {7'h19, 7'h30, 7'h24, 7'h0E}, 1'b0, -1, 0, 2'd0, 4'h0);
    run_frame("fD", {7'h19, 7'h30, 7'h08, 7'h0E}, 1'b0, -1, 0, 2'd0, 4'h0);
    check("nogap_dark_cycles", 32'(z_dark), 32'd0);
    check("nogap_period", 32'(z_period), 32'd16);
    check("nogap_pulses", 32'(z_pulses), 32'd5);
    for (int k = 0; k < 15; k++) tick();
    check("abort_pre", {frame_done, dig_n, seg_n}, {1'b0, 4'hB, 7'h30});
    enable = 1'b0;
    tick();
    check("abort_dark", {frame_done, dig_n, seg_n}, {1'b0, 4'hF, 7'h7F});
    tick();
    check("abort_idle", {frame_done, dig_n, seg_n}, {1'b0, 4'hF, 7'h7F});
    enable = 1'b1;
    run_frame("restart", {7'h19, 7'h30, 7'h08, 7'h0E}, 1'b1, -1, 0, 2'd0, 4'h0);
    repeat (3) tick();
    check("rst_mid_pre", {frame_done, dig_n, seg_n}, {1'b0, 4'hE, 7'h0E});
    rst_n = 1'b0;
    tick();
    check("rst_mid_dark", {frame_done, dig_n, seg_n}, {1'b0, 4'hF, 7'h7F});
    rst_n = 1'b1;
    run_frame("rst_clr", {4{7'h40}}, 1'b1, -1, 0, 2'd0, 4'h0);
    enable = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h5;
    tick();
    wr_en = 1'b0;
    enable = 1'b1;
    run_frame("lz_a", {Z_HI, Z_HI, Z_HI, 7'h12}, 1'b1, -1, 0, 2'd0, 4'h0);
    enable = 1'b0;
    tick();
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'h3;
    tick();
    wr_en = 1'b0;
    enable = 1'b1;
    run_frame("lz_b", {Z_HI, 7'h30, 7'h40, 7'h12}, 1'b1, -1, 0, 2'd0, 4'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
